// File: rtl/eq_decision_ctrl_pkg.sv
// Shared definitions for the equalizer decision controller: FSM encodings,
// step-size gear codes, PRBS seeds and fixed-point level helpers.
package eq_decision_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DD    = 2'd2,
    ST_LOCK  = 2'd3
  } eq_state_e;

  localparam logic [1:0] MU_SLOW = 2'd0;
  localparam logic [1:0] MU_MID  = 2'd1;
  localparam logic [1:0] MU_FAST = 2'd2;

  localparam int PRBS_W = 9;
  localparam logic [PRBS_W-1:0] PRBS_SEED_I = 9'h1FF;
  localparam logic [PRBS_W-1:0] PRBS_SEED_Q = 9'h0AA;

  // Constellation levels as integer codes for a given number of fractional bits
  function automatic int lvl_half(input int nbf);
    return 32'sd1 <<< (nbf - 1);
  endfunction

  function automatic int lvl_one(input int nbf);
    return 32'sd1 <<< nbf;
  endfunction

  function automatic int lvl_three_half(input int nbf);
    return 32'sd3 <<< (nbf - 1);
  endfunction

endpackage

// File: rtl/eq_decision_ctrl_prbs9.sv
// PRBS9 (x^9 + x^5 + 1) source advancing two steps per enable;
// o_bits[1] is the older of the two bits produced by the next advance.
module prbs9_gen
  import eq_decision_ctrl_pkg::*;
#(
  parameter logic [PRBS_W-1:0] SEED = 9'h1FF
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_reseed,
  input  logic       i_en,
  output logic [1:0] o_bits
);

  logic [PRBS_W-1:0] r_lfsr;

  // Two-step shift register; reseed has priority over advance
  always_ff @(posedge clk) begin
    if (i_reset || i_reseed) begin
      r_lfsr <= SEED;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[8] ^ r_lfsr[4], r_lfsr[7] ^ r_lfsr[3]};
    end
  end

  assign o_bits = r_lfsr[8:7];

endmodule

// File: rtl/eq_decision_ctrl.sv
// Decision controller for an adaptive equalizer: slicer / training reference,
// error generation, leaky MSE estimate and the TRAIN / DD / DD_LOCK sequencer.
module eq_decision_ctrl
  import eq_decision_ctrl_pkg::*;
#(
  parameter int NBT_IN       = 12,
  parameter int NBF_IN       = 9,
  parameter int NBT_ERR      = 12,
  parameter int NBF_ERR      = 9,
  parameter int NBT_MSE      = 16,
  parameter int NBF_MSE      = 14,
  parameter int MSE_AVG_LOG2 = 6,
  parameter int TRAIN_LEN    = 1024,
  parameter logic [NBT_MSE-1:0] LOCK_THR   = 16'h0100,
  parameter logic [NBT_MSE-1:0] UNLOCK_THR = 16'h0400,
  parameter int LOCK_CNT     = 32
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NBT_IN-1:0]  i_is_data_I,
  input  logic [NBT_IN-1:0]  i_is_data_Q,
  input  logic               i_valid,
  input  logic               i_mode,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_skip_train,
  output logic [NBT_IN-1:0]  o_sym_I,
  output logic [NBT_IN-1:0]  o_sym_Q,
  output logic [NBT_ERR-1:0] o_err_I,
  output logic [NBT_ERR-1:0] o_err_Q,
  output logic               o_err_valid,
  output logic [NBT_MSE-1:0] o_mse,
  output logic [1:0]         o_state,
  output logic               o_lock,
  output logic [1:0]         o_mu_sel
);

  localparam logic signed [NBT_IN-1:0] L_P05 = NBT_IN'(lvl_half(NBF_IN));
  localparam logic signed [NBT_IN-1:0] L_P10 = NBT_IN'(lvl_one(NBF_IN));
  localparam logic signed [NBT_IN-1:0] L_P15 = NBT_IN'(lvl_three_half(NBF_IN));
  localparam logic signed [NBT_IN-1:0] L_M05 = NBT_IN'(-lvl_half(NBF_IN));
  localparam logic signed [NBT_IN-1:0] L_M10 = NBT_IN'(-lvl_one(NBF_IN));
  localparam logic signed [NBT_IN-1:0] L_M15 = NBT_IN'(-lvl_three_half(NBF_IN));

  // Error path: align input fractional bits to the error format before saturating
  localparam int ERR_LSH = (NBF_ERR >= NBF_IN) ? NBF_ERR - NBF_IN : 0;
  localparam int ERR_RSH = (NBF_IN > NBF_ERR) ? NBF_IN - NBF_ERR : 0;
  localparam int W_D = (NBT_IN + 2 + ERR_LSH > NBT_ERR + 1) ? NBT_IN + 2 + ERR_LSH : NBT_ERR + 1;
  localparam logic signed [W_D-1:0] ERR_MAX = W_D'((32'sd1 <<< (NBT_ERR - 1)) - 32'sd1);
  localparam logic signed [W_D-1:0] ERR_MIN = W_D'(-(32'sd1 <<< (NBT_ERR - 1)));

  localparam int SQ_LSH = (NBF_MSE > 2 * NBF_ERR) ? NBF_MSE - 2 * NBF_ERR : 0;
  localparam int SQ_RSH = (2 * NBF_ERR > NBF_MSE) ? 2 * NBF_ERR - NBF_MSE : 0;
  localparam int W_SQ = (2 * NBT_ERR + 1 + SQ_LSH > NBT_MSE + 1) ? 2 * NBT_ERR + 1 + SQ_LSH : NBT_MSE + 1;
  localparam logic [W_SQ-1:0] SQ_MAX = W_SQ'({NBT_MSE{1'b1}});

  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);
  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CNT - 1);

  function automatic logic [NBT_IN-1:0] slice(input logic signed [NBT_IN-1:0] y, input logic mode);
    logic [NBT_IN-1:0] d;
    if (mode == 1'b0) begin
      d = y[NBT_IN-1] ? L_M10 : L_P10;
    end else if (y >= L_P10) begin
      d = L_P15;
    end else if (y[NBT_IN-1] == 1'b0) begin
      d = L_P05;
    end else if (y >= L_M10) begin
      d = L_M05;
    end else begin
      d = L_M15;
    end
    return d;
  endfunction

  function automatic logic [NBT_IN-1:0] train_sym(input logic [1:0] b, input logic mode);
    logic [NBT_IN-1:0] d;
    if (mode == 1'b0) begin
      d = b[1] ? L_M10 : L_P10;
    end else if (b[1]) begin
      d = b[0] ? L_M15 : L_M05;
    end else begin
      d = b[0] ? L_P15 : L_P05;
    end
    return d;
  endfunction

  function automatic logic [NBT_ERR-1:0] sat_err(input logic signed [W_D-1:0] v);
    logic [NBT_ERR-1:0] r;
    if (v > ERR_MAX) begin
      r = ERR_MAX[NBT_ERR-1:0];
    end else if (v < ERR_MIN) begin
      r = ERR_MIN[NBT_ERR-1:0];
    end else begin
      r = v[NBT_ERR-1:0];
    end
    return r;
  endfunction

  eq_state_e r_state, w_state_nxt;
  logic [1:0] w_mu_nxt, r_mu_sel;
  logic r_lock;

  logic [NBT_IN-1:0]  r_sym_i, r_sym_q, w_dec_i, w_dec_q, w_ref_i, w_ref_q;
  logic [NBT_ERR-1:0] r_err_i, r_err_q, w_err_i, w_err_q;
  logic               r_err_valid;
  logic signed [W_D-1:0] w_diff_i, w_diff_q;
  logic [1:0] w_prbs_i, w_prbs_q;
  logic       w_prbs_en;

  logic [15:0] r_sym_cnt, r_lock_cnt;
  logic [NBT_MSE-1:0] r_mse, w_sq_sat, w_mse_nxt;
  logic signed [2*NBT_ERR-1:0] w_sq_i, w_sq_q;
  logic [W_SQ-1:0] w_sq_sum, w_sq_al;
  logic signed [NBT_MSE+1:0] w_mse_diff, w_mse_step, w_mse_sum;
  logic w_below, w_unlock;

  assign w_prbs_en = i_valid && (r_state == ST_TRAIN);
  assign w_below   = (r_mse < LOCK_THR);
  assign w_unlock  = (r_mse > UNLOCK_THR);

  prbs9_gen #(.SEED(PRBS_SEED_I)) u_prbs_i (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_reseed (i_start),
    .i_en     (w_prbs_en),
    .o_bits   (w_prbs_i)
  );

  prbs9_gen #(.SEED(PRBS_SEED_Q)) u_prbs_q (
    .clk      (clk),
    .i_reset  (i_reset),
    .i_reseed (i_start),
    .i_en     (w_prbs_en),
    .o_bits   (w_prbs_q)
  );

  // Decision, reference selection and saturated error
  always_comb begin
    w_dec_i = slice($signed(i_is_data_I), i_mode);
    w_dec_q = slice($signed(i_is_data_Q), i_mode);
    if (r_state == ST_TRAIN) begin
      w_ref_i = train_sym(w_prbs_i, i_mode);
      w_ref_q = train_sym(w_prbs_q, i_mode);
    end else begin
      w_ref_i = w_dec_i;
      w_ref_q = w_dec_q;
    end
    w_diff_i = ((W_D'($signed(i_is_data_I)) - W_D'($signed(w_ref_i))) <<< ERR_LSH) >>> ERR_RSH;
    w_diff_q = ((W_D'($signed(i_is_data_Q)) - W_D'($signed(w_ref_q))) <<< ERR_LSH) >>> ERR_RSH;
    w_err_i  = sat_err(w_diff_i);
    w_err_q  = sat_err(w_diff_q);
  end

  // Squared error and leaky-average update; floor shift lets the estimate reach 0
  always_comb begin
    w_sq_i   = $signed(r_err_i) * $signed(r_err_i);
    w_sq_q   = $signed(r_err_q) * $signed(r_err_q);
    w_sq_sum = W_SQ'($unsigned(w_sq_i)) + W_SQ'($unsigned(w_sq_q));
    w_sq_al  = (w_sq_sum << SQ_LSH) >> SQ_RSH;
    if (w_sq_al > SQ_MAX) begin
      w_sq_sat = {NBT_MSE{1'b1}};
    end else begin
      w_sq_sat = w_sq_al[NBT_MSE-1:0];
    end
    w_mse_diff = $signed({2'b00, w_sq_sat}) - $signed({2'b00, r_mse});
    w_mse_step = w_mse_diff >>> MSE_AVG_LOG2;
    w_mse_sum  = $signed({2'b00, r_mse}) + w_mse_step;
    if (w_mse_sum[NBT_MSE+1]) begin
      w_mse_nxt = {NBT_MSE{1'b0}};
    end else if (w_mse_sum[NBT_MSE]) begin
      w_mse_nxt = {NBT_MSE{1'b1}};
    end else begin
      w_mse_nxt = w_mse_sum[NBT_MSE-1:0];
    end
  end

  // Symbol/error output registers, one cycle behind i_valid, silent in IDLE
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_sym_i     <= {NBT_IN{1'b0}};
      r_sym_q     <= {NBT_IN{1'b0}};
      r_err_i     <= {NBT_ERR{1'b0}};
      r_err_q     <= {NBT_ERR{1'b0}};
      r_err_valid <= 1'b0;
    end else if (i_valid && (r_state != ST_IDLE)) begin
      r_sym_i     <= w_dec_i;
      r_sym_q     <= w_dec_q;
      r_err_i     <= w_err_i;
      r_err_q     <= w_err_q;
      r_err_valid <= 1'b1;
    end else begin
      r_err_valid <= 1'b0;
    end
  end

  // Training/lock counters and MSE estimate
  always_ff @(posedge clk) begin
    if (i_reset || i_start) begin
      r_sym_cnt  <= 16'd0;
      r_lock_cnt <= 16'd0;
      r_mse      <= {NBT_MSE{1'b1}};
    end else begin
      if (r_err_valid) begin
        r_mse <= w_mse_nxt;
      end
      if (i_valid) begin
        case (r_state)
          ST_TRAIN: r_sym_cnt  <= (r_sym_cnt == TRAIN_LAST) ? 16'd0 : r_sym_cnt + 16'd1;
          ST_DD:    r_lock_cnt <= w_below ? r_lock_cnt + 16'd1 : 16'd0;
          ST_LOCK:  r_lock_cnt <= w_unlock ? 16'd0 : r_lock_cnt;
          default:  r_lock_cnt <= r_lock_cnt;
        endcase
      end
    end
  end

  // Next-state and step-size gear; stop outranks start
  always_comb begin
    w_state_nxt = r_state;
    w_mu_nxt    = MU_SLOW;
    if (i_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (i_start) begin
      if (i_skip_train) begin
        w_state_nxt = ST_DD;
      end else begin
        w_state_nxt = ST_TRAIN;
      end
    end else if (i_valid) begin
      case (r_state)
        ST_TRAIN: w_state_nxt = (r_sym_cnt == TRAIN_LAST) ? ST_DD : ST_TRAIN;
        ST_DD:    w_state_nxt = (w_below && (r_lock_cnt == LOCK_LAST)) ? ST_LOCK : ST_DD;
        ST_LOCK:  w_state_nxt = w_unlock ? ST_DD : ST_LOCK;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end else begin
      w_state_nxt = r_state;
    end
    case (w_state_nxt)
      ST_TRAIN: w_mu_nxt = MU_FAST;
      ST_DD:    w_mu_nxt = MU_MID;
      default:  w_mu_nxt = MU_SLOW;
    endcase
  end

  // State register with lock/gear outputs registered alongside it
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_lock   <= 1'b0;
      r_mu_sel <= MU_SLOW;
    end else begin
      r_state  <= w_state_nxt;
      r_lock   <= (w_state_nxt == ST_LOCK);
      r_mu_sel <= w_mu_nxt;
    end
  end

  assign o_sym_I     = r_sym_i;
  assign o_sym_Q     = r_sym_q;
  assign o_err_I     = r_err_i;
  assign o_err_Q     = r_err_q;
  assign o_err_valid = r_err_valid;
  assign o_mse       = r_mse;
  assign o_state     = r_state;
  assign o_lock      = r_lock;
  assign o_mu_sel    = r_mu_sel;

endmodule

// File: tb/tb_eq_decision_ctrl.sv
// Directed bench for eq_decision_ctrl: slicer vector table, training reference,
// MSE decay / lock / unlock, and control corner cases.
module tb_eq_decision_ctrl;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_mode, i_start, i_stop, i_skip_train;
  logic [11:0] i_is_data_I, i_is_data_Q;
  logic [11:0] o_sym_I, o_sym_Q, o_err_I, o_err_Q;
  logic        o_err_valid, o_lock;
  logic [15:0] o_mse;
  logic [1:0]  o_state, o_mu_sel;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] c_sym_i, c_sym_q, c_err_i, c_err_q;
  logic        c_ev, c_ev_after;
  logic [8:0]  m_pi, m_pq;

  typedef struct {
    logic        mode;
    logic [11:0] yi, yq, si, ei, sq, eq;
  } vec_t;
  vec_t vecs[9];

  eq_decision_ctrl #(.TRAIN_LEN(16)) dut (
    .clk(clk), .i_reset(i_reset), .i_is_data_I(i_is_data_I), .i_is_data_Q(i_is_data_Q),
    .i_valid(i_valid), .i_mode(i_mode), .i_start(i_start), .i_stop(i_stop),
    .i_skip_train(i_skip_train), .o_sym_I(o_sym_I), .o_sym_Q(o_sym_Q),
    .o_err_I(o_err_I), .o_err_Q(o_err_Q), .o_err_valid(o_err_valid), .o_mse(o_mse),
    .o_state(o_state), .o_lock(o_lock), .o_mu_sel(o_mu_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sym(input logic [11:0] yi, input logic [11:0] yq, input logic mode);
    i_is_data_I = yi;
    i_is_data_Q = yq;
    i_mode      = mode;
    i_valid     = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    c_sym_i = o_sym_I;
    c_sym_q = o_sym_Q;
    c_err_i = o_err_I;
    c_err_q = o_err_Q;
    c_ev    = o_err_valid;
    @(posedge clk); #1;
    c_ev_after = o_err_valid;
  endtask

  task automatic pulse_start(input logic skip);
    i_start      = 1'b1;
    i_skip_train = skip;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic prbs_pair(input logic [8:0] s_in, output logic [8:0] s_out, output logic [1:0] b);
    logic [8:0] s;
    s = s_in;
    for (int k = 0; k < 2; k++) begin
      b[1-k] = s[8];
      s = {s[7:0], s[8] ^ s[4]};
    end
    s_out = s;
  endtask

  function automatic int ref_level(input logic [1:0] b, input logic mode);
    int mag;
    if (!mode) return b[1] ? -512 : 512;
    mag = b[0] ? 768 : 256;
    return b[1] ? -mag : mag;
  endfunction

  function automatic int mse_upd(input int m, input int sq);
    int d;
    d = sq - m;
    if (d >= 0) return m + d / 64;
    return m - ((-d + 63) / 64);
  endfunction

  initial begin
    logic [1:0]  bi, bq;
    logic [11:0] e;
    int          mm, cnt;
    logic        locked;

    vecs[0] = '{1'b0, 12'h19A, 12'hE66, 12'h200, 12'hF9A, 12'hE00, 12'h066};
    vecs[1] = '{1'b0, 12'h000, 12'hFFF, 12'h200, 12'hE00, 12'hE00, 12'h1FF};
    vecs[2] = '{1'b1, 12'h266, 12'h200, 12'h300, 12'hF66, 12'h300, 12'hF00};
    vecs[3] = '{1'b1, 12'h200, 12'hE00, 12'h300, 12'hF00, 12'hF00, 12'hF00};
    vecs[4] = '{1'b1, 12'hE00, 12'h000, 12'hF00, 12'hF00, 12'h100, 12'hF00};
    vecs[5] = '{1'b1, 12'h000, 12'h1FF, 12'h100, 12'hF00, 12'h100, 12'h0FF};
    vecs[6] = '{1'b1, 12'hDFF, 12'hFFF, 12'hD00, 12'h0FF, 12'hF00, 12'h0FF};
    vecs[7] = '{1'b1, 12'h7FF, 12'h800, 12'h300, 12'h4FF, 12'hD00, 12'hB00};
    vecs[8] = '{1'b0, 12'h800, 12'h7FF, 12'hE00, 12'hA00, 12'h200, 12'h5FF};

    i_reset = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    i_skip_train = 1'b0; i_is_data_I = 12'h000; i_is_data_Q = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", o_state, 0);
    check("rst_mse", o_mse, 16'hFFFF);
    check("rst_sym", {o_sym_I, o_sym_Q}, 0);
    check("rst_err", {o_err_I, o_err_Q}, 0);
    check("rst_err_valid", o_err_valid, 0);
    check("rst_lock", o_lock, 0);
    check("rst_mu_sel", o_mu_sel, 0);
    i_reset = 1'b0;

    sym(12'h19A, 12'h000, 1'b0);
    check("idle_err_valid", c_ev, 0);
    check("idle_state", o_state, 0);

    pulse_start(1'b1);
    check("skip_state", o_state, 2);
    check("skip_mu_sel", o_mu_sel, 1);
    for (int v = 0; v < 9; v++) begin
      sym(vecs[v].yi, vecs[v].yq, vecs[v].mode);
      check($sformatf("vec%0d_sym_I", v), c_sym_i, vecs[v].si);
      check($sformatf("vec%0d_err_I", v), c_err_i, vecs[v].ei);
      check($sformatf("vec%0d_sym_Q", v), c_sym_q, vecs[v].sq);
      check($sformatf("vec%0d_err_Q", v), c_err_q, vecs[v].eq);
      check($sformatf("vec%0d_err_valid", v), c_ev, 1);
      check($sformatf("vec%0d_state", v), o_state, 2);
    end
    check("err_valid_one_cycle", c_ev_after, 0);

    pulse_start(1'b0);
    check("train_state", o_state, 1);
    check("train_mu_sel", o_mu_sel, 2);
    m_pi = 9'h1FF;
    m_pq = 9'h0AA;
    for (int k = 0; k < 16; k++) begin
      prbs_pair(m_pi, m_pi, bi);
      prbs_pair(m_pq, m_pq, bq);
      sym(12'h000, 12'h000, 1'b1);
      e = 12'(-ref_level(bi, 1'b1));
      check($sformatf("train%0d_err_I", k), c_err_i, e);
      e = 12'(-ref_level(bq, 1'b1));
      check($sformatf("train%0d_err_Q", k), c_err_q, e);
      if (k == 14) check("train15_state", o_state, 1);
      if (k == 15) begin
        check("train_done_state", o_state, 2);
        check("train_done_mu_sel", o_mu_sel, 1);
      end
    end
    sym(12'h000, 12'h000, 1'b1);
    check("post_train_dd_err", c_err_i, 12'hF00);

    pulse_start(1'b1);
    mm = 65535; cnt = 0; locked = 1'b0;
    for (int n = 0; n < 1500 && !(locked && mm == 0); n++) begin
      if (!locked) begin
        if (mm < 256) cnt++;
        else cnt = 0;
        if (cnt == 32) locked = 1'b1;
      end
      sym(12'h200, 12'hE00, 1'b0);
      mm = mse_upd(mm, 0);
      check($sformatf("lock_flag%0d", n), o_lock, locked);
      check($sformatf("mse_decay%0d", n), o_mse, mm);
    end
    check("locked_state", o_state, 3);
    check("locked_mu_sel", o_mu_sel, 0);
    check("mse_zero", o_mse, 0);

    for (int n = 0; n < 20 && locked; n++) begin
      if (mm > 1024) locked = 1'b0;
      sym(12'h000, 12'h000, 1'b0);
      if (n == 0) check("unlock_err_I", c_err_i, 12'hE00);
      mm = mse_upd(mm, 32768);
      check($sformatf("unlock_flag%0d", n), o_lock, locked);
      check($sformatf("mse_rise%0d", n), o_mse, mm);
    end
    check("unlocked_state", o_state, 2);
    check("unlocked_mu_sel", o_mu_sel, 1);

    i_start = 1'b1; i_stop = 1'b1; i_skip_train = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0; i_stop = 1'b0;
    check("start_stop_state", o_state, 0);
    check("start_stop_mu_sel", o_mu_sel, 0);
    check("start_stop_lock", o_lock, 0);

    pulse_start(1'b0);
    repeat (5) sym(12'h000, 12'h000, 1'b0);
    check("mid_train_state", o_state, 1);
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    check("mid_rst_state", o_state, 0);
    check("mid_rst_sym", {o_sym_I, o_sym_Q}, 0);
    check("mid_rst_err", {o_err_I, o_err_Q}, 0);
    check("mid_rst_err_valid", o_err_valid, 0);
    check("mid_rst_lock", o_lock, 0);
    check("mid_rst_mu_sel", o_mu_sel, 0);
    check("mid_rst_mse", o_mse, 16'hFFFF);
    sym(12'h000, 12'h000, 1'b0);
    check("after_rst_no_valid", c_ev, 0);
    check("after_rst_idle", o_state, 0);

    pulse_start(1'b0);
    m_pi = 9'h1FF;
    m_pq = 9'h0AA;
    prbs_pair(m_pi, m_pi, bi);
    prbs_pair(m_pq, m_pq, bq);
    sym(12'h000, 12'h000, 1'b0);
    e = 12'(-ref_level(bi, 1'b0));
    check("restart_err_I", c_err_i, e);
    e = 12'(-ref_level(bq, 1'b0));
    check("restart_err_Q", c_err_q, e);
    check("restart_state", o_state, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/eq_decision_ctrl.md
EQ_DECISION_CTRL -- requirements
Module: eq_decision_ctrl

Interface
REQ-001 Parameter NBT_IN, default 12: total bits of the equalizer output sample, S(NBT_IN,NBF_IN).
REQ-002 Parameter NBF_IN, default 9: fractional bits of the input sample.
REQ-003 Parameter NBT_ERR / NBF_ERR, default 12 / 9: error word format S(NBT_ERR,NBF_ERR).
REQ-004 Parameter NBT_MSE / NBF_MSE, default 16 / 14: MSE estimate format U(NBT_MSE,NBF_MSE).
REQ-005 Parameter MSE_AVG_LOG2, default 6: leaky-average shift (window of about 64 symbols).
REQ-006 Parameter TRAIN_LEN, default 1024: number of training symbols; range 1..65535.
REQ-007 Parameters LOCK_THR / UNLOCK_THR, defaults 16'h0100 / 16'h0400: MSE thresholds; LOCK_THR SHALL be less than UNLOCK_THR.
REQ-008 Parameter LOCK_CNT, default 32: consecutive below-threshold symbols required to declare lock.
REQ-009 clk  in  1  sole clock, rising edge.
REQ-010 i_reset  in  1  synchronous, active-high reset.
REQ-011 i_is_data_I / i_is_data_Q  in  NBT_IN  rate-1 equalizer output sample.
REQ-012 i_valid  in  1  input sample qualifier, one pulse per symbol.
REQ-013 i_mode  in  1  constellation select: 0 = QPSK (2 levels per axis), 1 = 16QAM (4 levels per axis).
REQ-014 i_start / i_stop  in  1  single-cycle control pulses.
REQ-015 i_skip_train  in  1  when 1, i_start enters decision-directed mode directly.
REQ-016 o_sym_I / o_sym_Q  out  NBT_IN  decided symbol, same format as the input.
REQ-017 o_err_I / o_err_Q  out  NBT_ERR  error term y - reference, for the LMS engine.
REQ-018 o_err_valid  out  1  error qualifier.
REQ-019 o_mse  out  NBT_MSE  averaged squared-error estimate.
REQ-020 o_state  out  2  FSM state; o_lock  out  1  lock indicator; o_mu_sel  out  2  step-size gear.

Function
REQ-021 The slicer SHALL operate as follows. QPSK: y >= 0 -> +1.0, otherwise -1.0. 16QAM: y >= 1.0 -> +1.5; 0 <= y < 1.0 -> +0.5; -1.0 <= y < 0 -> -0.5; y < -1.0 -> -1.5.
REQ-022 The reference SHALL be the slicer decision in the DD and DD_LOCK states, and the training symbol in TRAIN.
REQ-023 Training symbols SHALL come from two PRBS9 generators (x^9+x^5+1), seeded I = 9'h1FF and Q = 9'h0AA, each advancing 2 steps per valid symbol during TRAIN.
REQ-024 Training symbol mapping (b1 = older bit): QPSK gives b1 ? -1.0 : +1.0. 16QAM gives sign = b1, magnitude = b0 ? 1.5 : 0.5.
REQ-025 The error SHALL be y - reference, computed at full precision and then saturated to S(NBT_ERR,NBF_ERR).
REQ-026 o_sym, o_err and o_err_valid SHALL be registered, with a latency of 1 cycle after i_valid. o_err_valid SHALL equal i_valid delayed by 1 cycle, and SHALL be 0 in IDLE.
REQ-027 The squared error SHALL be computed as sq = err_I^2 + err_Q^2, truncated to NBF_MSE fractional bits and saturated to NBT_MSE bits.
REQ-028 On each o_err_valid, the MSE SHALL update as mse += (sq - mse) >>> MSE_AVG_LOG2, using an arithmetic (flooring) shift so that the estimate decays to 0.
REQ-029 FSM states SHALL be IDLE = 0, TRAIN = 1, DD = 2, DD_LOCK = 3.
REQ-030 IDLE: i_start SHALL move to TRAIN, or to DD if i_skip_train = 1.
REQ-031 TRAIN: the symbol counter SHALL increment per valid symbol; the FSM SHALL move to DD on the valid symbol at which the count equals TRAIN_LEN-1.
REQ-032 DD: the lock counter SHALL increment on each valid symbol with mse < LOCK_THR and clear otherwise; reaching LOCK_CNT SHALL move the FSM to DD_LOCK.
REQ-033 DD_LOCK: a valid symbol with mse > UNLOCK_THR SHALL move the FSM to DD and clear the lock counter.
REQ-034 i_start in any state SHALL restart the sequence: PRBS reseeded, counters cleared, mse set to all-ones, FSM to TRAIN or DD per i_skip_train.
REQ-035 i_stop SHALL move the FSM to IDLE from any state; if i_start and i_stop coincide, i_stop SHALL win.
REQ-036 o_lock SHALL be 1 only in DD_LOCK. o_mu_sel SHALL be 2 in TRAIN, 1 in DD, and 0 in DD_LOCK and IDLE.
REQ-037 i_mode SHALL be sampled per valid symbol; changing it mid-stream SHALL take effect on the next symbol with no state change.

Reset
REQ-038 While i_reset = 1 at a clk edge, the block SHALL set: FSM = IDLE; all counters = 0; PRBS generators reseeded; mse = all-ones; o_sym = 0; o_err = 0; o_err_valid = 0; o_lock = 0; o_mu_sel = 0.
REQ-039 Reset asserted mid-TRAIN SHALL abandon training; after reset, operation SHALL resume only on a new i_start.

Structure
REQ-040 The shared package SHALL hold the state encodings, the mu_sel codes, and the level constants (0.5, 1.0, 1.5) expressed as functions of NBF_IN.
REQ-041 A single sub-module, prbs9_gen (2 bits per step, with seed parameter, enable and reseed inputs), SHALL be instantiated twice.

Verification
REQ-042 Slicer, QPSK, DD: input I = 0x19A (+0.8) -> o_sym_I = 0x200, o_err_I = 0xF9A, both 1 cycle after i_valid.
REQ-043 Slicer, 16QAM: inputs 0x266, 0x200, 0xE00, 0x000 -> o_sym_I = 0x300, 0x300, 0xF00, 0x100; err for 0x266 = 0xF66.
REQ-044 Training: TRAIN_LEN = 16, i_start, then 16 valid symbols -> o_state goes 1 -> 2 after the 16th symbol; o_mu_sel goes 2 -> 1; reference bits match a PRBS9 golden model.
REQ-045 Lock: exact constellation inputs in DD with LOCK_CNT = 32 -> mse decays to 0, and o_lock rises after 32 below-threshold symbols. Then inject y = 0 on both axes (sq = 2.0) -> o_lock falls once mse exceeds UNLOCK_THR.
REQ-046 Control corner cases: i_start and i_stop in the same cycle -> IDLE; i_reset at TRAIN count 5 -> IDLE with all outputs 0; a following i_start -> training restarts from seed.
